// File: rtl/dwt_pkg.sv
// Shared definitions for the 3-level inverse Haar-lifting reconstruction slice.
//   DATA_W_DEFAULT / COEF_W_DEFAULT : default sample / coefficient widths
//   FRAME_LEN                       : coefficients (and samples) per frame
//   LEVELS                          : decomposition depth of a frame
//   idwt_state_t                    : controller states
package dwt_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned COEF_W_DEFAULT = DATA_W_DEFAULT + 3;
  localparam int unsigned FRAME_LEN      = 8;
  localparam int unsigned LEVELS         = 3;

  typedef enum logic [2:0] {
    LOAD,
    L3,
    L2,
    L1,
    OUT
  } idwt_state_t;

endpackage

// File: rtl/idwt_lift_pe.sv
// Combinational inverse lifting step on one (approximation, detail) pair.
//   s : approximation input      d : detail input
//   e : even output = s - floor(d/2)
//   o : odd output  = d + e
// All arithmetic wraps in COEF_W bits.
module idwt_lift_pe #(
  parameter int unsigned COEF_W = 19
) (
  input  logic signed [COEF_W-1:0] s,
  input  logic signed [COEF_W-1:0] d,
  output logic signed [COEF_W-1:0] e,
  output logic signed [COEF_W-1:0] o
);

  always_comb begin
    e = s - (d >>> 1);
    o = d + e;
  end

endmodule

// File: rtl/idwt_recon.sv
// Frame-based 3-level inverse wavelet reconstruction.
// Accepts 8 coefficients (a3, d3, d2[0..1], d1[0..3]) over a valid/ready
// stream, runs one lifting step per cycle (1 + 2 + 4 cycles) through a
// single shared PE, then emits x[0..7] over a valid/ready stream.
//   clk, reset                       : clock, async active-high reset
//   coef_valid/ready/data/last       : coefficient input stream
//   sample_valid/ready/data/last     : reconstructed sample output stream
//   busy                             : high whenever not loading
//   frame_err                        : one-cycle pulse on a framing violation
module idwt_recon
  import dwt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned COEF_W = DATA_W + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_last,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_last,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  idwt_state_t state, state_nxt;

  logic [IDX_W-1:0] coef_idx;
  logic [IDX_W-1:0] out_idx;
  logic [1:0]       step;

  logic signed [COEF_W-1:0] cbuf [FRAME_LEN];
  logic signed [COEF_W-1:0] a2   [2];
  logic signed [COEF_W-1:0] a1   [4];
  logic        [DATA_W-1:0] xs   [FRAME_LEN];

  logic signed [COEF_W-1:0] pe_s, pe_d, pe_e, pe_o;

  logic coef_fire;
  logic sample_fire;

  assign coef_ready   = (state == LOAD);
  assign sample_valid = (state == OUT);
  assign busy         = (state != LOAD);
  assign sample_last  = sample_valid && (out_idx == IDX_LAST);
  // Gated so that the unreset sample buffer never shows on the port.
  assign sample_data  = sample_valid ? xs[out_idx] : '0;

  assign coef_fire   = coef_valid && coef_ready;
  assign sample_fire = sample_valid && sample_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: if (coef_fire && coef_idx == IDX_LAST) state_nxt = L3;
      L3:   state_nxt = L2;
      L2:   if (step == 2'd1) state_nxt = L1;
      L1:   if (step == 2'd3) state_nxt = OUT;
      OUT:  if (sample_fire && out_idx == IDX_LAST) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_idx  <= '0;
      out_idx   <= '0;
      step      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (coef_fire) begin
        if (coef_idx == IDX_LAST) begin
          coef_idx  <= '0;
          frame_err <= !coef_last;
        end else if (coef_last) begin
          // Early last: drop the partial frame by restarting the index.
          coef_idx  <= '0;
          frame_err <= 1'b1;
        end else begin
          coef_idx <= coef_idx + IDX_W'(1);
        end
      end
      if (state == L2)      step <= (step == 2'd1) ? 2'd0 : step + 2'd1;
      else if (state == L1) step <= (step == 2'd3) ? 2'd0 : step + 2'd1;
      else                  step <= '0;
      if (sample_fire) out_idx <= out_idx + IDX_W'(1);
    end
  end

  // Operand selection for the shared PE: detail index within the frame
  // is 1 for L3, 2+k for L2, 4+k for L1.
  always_comb begin
    pe_s = cbuf[0];
    pe_d = cbuf[1];
    if (state == L2) begin
      pe_s = a2[step[0]];
      pe_d = cbuf[{2'b01, step[0]}];
    end else if (state == L1) begin
      pe_s = a1[step];
      pe_d = cbuf[{1'b1, step}];
    end
  end

  idwt_lift_pe #(
    .COEF_W (COEF_W)
  ) u_pe (
    .s (pe_s),
    .d (pe_d),
    .e (pe_e),
    .o (pe_o)
  );

  always_ff @(posedge clk) begin
    if (coef_fire) cbuf[coef_idx] <= coef_data;
    unique case (state)
      L3: begin
        a2[0] <= pe_e;
        a2[1] <= pe_o;
      end
      L2: begin
        a1[{step[0], 1'b0}] <= pe_e;
        a1[{step[0], 1'b1}] <= pe_o;
      end
      L1: begin
        xs[{step, 1'b0}] <= pe_e[DATA_W-1:0];
        xs[{step, 1'b1}] <= pe_o[DATA_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_idwt_recon.sv
// Scoreboard bench for idwt_recon: the stimulus pushes hand-computed samples
// into a queue, and a negedge monitor pops/compares on every sample transfer
// and checks output stability during back-pressure stalls.
module tb_idwt_recon;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned COEF_W = 19;

  typedef logic signed [COEF_W-1:0] frame_t [8];
  typedef logic [DATA_W-1:0]        exp_t   [8];
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } sb_t;

  logic              clk;
  logic              reset;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic              coef_last;
  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] sample_data;
  logic              sample_last;
  logic              busy;
  logic              frame_err;

  int checks     = 0;
  int failures   = 0;
  int err_pulses = 0;
  bit rand_ready = 0;
  bit chk_rb     = 0;
  sb_t sbq[$];

  frame_t frame_a, frame_b, frame_w;
  exp_t   exp_a, exp_b, exp_w;

  idwt_recon #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_data    (coef_data),
    .coef_last    (coef_last),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .sample_last  (sample_last),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input exp_t e);
    for (int i = 0; i < 8; i++) begin
      sb_t s;
      s.data = e[i];
      s.last = (i == 7);
      sbq.push_back(s);
    end
  endtask

  // Leaves coef_valid as-is after the final word so frames can be chained.
  task automatic send_coefs(input frame_t f, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      int cnt;
      coef_valid = 1'b1;
      coef_data  = f[i];
      coef_last  = (i == last_at);
      cnt = 0;
      @(negedge clk);
      while (!coef_ready && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      if (!coef_ready) chk("coef_accept_timeout", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;
    end
    coef_last = 1'b0;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (sbq.size() != 0 && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    chk("drain_remaining", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      sample_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic              held;
  logic [DATA_W-1:0] held_data;
  logic              held_last;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (frame_err) err_pulses++;
      if (chk_rb) chk("coef_ready_vs_busy", 32'(coef_ready), 32'(!busy));
      if (held) begin
        chk("stall_data", 32'(sample_data), 32'(held_data));
        chk("stall_last", 32'(sample_last), 32'(held_last));
      end
      held = 1'b0;
      if (sample_valid) begin
        if (sample_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sample actual=%0h expected=none", sample_data);
          end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("sample_data", 32'(sample_data), 32'(e.data));
            chk("sample_last", 32'(sample_last), 32'(e.last));
          end
        end else begin
          held      = 1'b1;
          held_data = sample_data;
          held_last = sample_last;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int cnt;
    frame_a = '{19'sd13, 19'sd0, 19'sd4, -19'sd14, 19'sd2, 19'sd2, 19'sd0, -19'sd4};
    exp_a   = '{16'd10, 16'd12, 16'd14, 16'd16, 16'd20, 16'd20, 16'd8, 16'd4};
    frame_b = '{19'sd0, -19'sd1, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_b   = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    // Max positive a3 with d3=-2 wraps e to -2^18 and o to 2^18-2.
    frame_w = '{19'sh3FFFF, -19'sd2, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0, 19'sd0};
    exp_w   = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};

    reset = 1'b1;
    coef_valid = 1'b0;
    coef_data = '0;
    coef_last = 1'b0;
    sample_ready = 1'b1;
    #1;
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample_last", 32'(sample_last), 32'd0);
    chk("rst_sample_data", 32'(sample_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_coef_ready", 32'(coef_ready), 32'd1);

    // Basic frame plus latency from the last coefficient transfer.
    push_exp(exp_a);
    send_coefs(frame_a, 8, 7);
    coef_valid = 1'b0;
    cnt = 0;
    @(negedge clk);
    chk("busy_after_load", 32'(busy), 32'd1);
    while (!sample_valid && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    chk("first_sample_latency", 32'(cnt), 32'd7);
    drain();

    // Odd negative detail exercises the floor in the shift.
    push_exp(exp_b);
    send_coefs(frame_b, 8, 7);
    coef_valid = 1'b0;
    drain();

    // Overflow wraps in coefficient width.
    push_exp(exp_w);
    send_coefs(frame_w, 8, 7);
    coef_valid = 1'b0;
    drain();

    // Random back-pressure.
    rand_ready = 1'b1;
    push_exp(exp_a);
    send_coefs(frame_a, 8, 7);
    coef_valid = 1'b0;
    drain();
    rand_ready = 1'b0;

    // Early last on the 3rd coefficient discards the partial frame.
    send_coefs(frame_b, 3, 2);
    coef_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("early_last_err_pulses", 32'(err_pulses), 32'd1);
    chk("early_last_ready", 32'(coef_ready), 32'd1);
    chk("early_last_no_sample", 32'(sample_valid), 32'd0);
    @(posedge clk);
    #1;
    push_exp(exp_a);
    send_coefs(frame_a, 8, 7);
    coef_valid = 1'b0;
    drain();

    // Missing last on the 8th coefficient: flagged but reconstructed.
    push_exp(exp_a);
    send_coefs(frame_a, 8, -1);
    coef_valid = 1'b0;
    drain();
    chk("missing_last_err_pulses", 32'(err_pulses), 32'd2);

    // Reset in the middle of a frame.
    send_coefs(frame_b, 5, -1);
    coef_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sample_valid", 32'(sample_valid), 32'd0);
    chk("midrst_sample_data", 32'(sample_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_coef_ready", 32'(coef_ready), 32'd1);
    push_exp(exp_a);
    send_coefs(frame_a, 8, 7);
    coef_valid = 1'b0;
    drain();

    // Back-to-back frames with coef_valid held high throughout.
    chk_rb = 1'b1;
    push_exp(exp_a);
    send_coefs(frame_a, 8, 7);
    push_exp(exp_b);
    send_coefs(frame_b, 8, 7);
    coef_valid = 1'b0;
    drain();
    chk_rb = 1'b0;
    chk("total_err_pulses", 32'(err_pulses), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
